vic_irq_arbiter: RTL and testbench
==================================

# vic_irq_arbiter

Upstream interrupt source of the vectored interrupt controller stage. Latches rising edges on up to N_SRC peripheral interrupt lines into a pending register, selects the highest-priority enabled pending source, and presents a one-cycle IRQ strobe together with that source's programmed ISR address. It then holds off further requests until the pipeline signals return-from-interrupt. On that return it tail-chains straight into the next pending source.

## Interface
- N_SRC, 8, number of interrupt sources (2..16); index 0 is highest priority
- ADDR_W, 32, ISR vector width
- ID_W, $clog2(N_SRC), source index width (derived, not overridable)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous and active-low; asserts immediately, deasserts synchronously to clk
- i_irq_src  in  N_SRC  peripheral interrupt lines, level, rising edge = event
- i_cfg_vec_we  in  1  write strobe for vector table
- i_cfg_idx  in  ID_W  vector table entry to write
- i_cfg_vec  in  ADDR_W  ISR address to store
- i_cfg_en_we  in  1  write strobe for enable mask
- i_cfg_en  in  N_SRC  new enable mask (1 = source may be granted)
- i_reti  in  1  ISR finished, one-cycle pulse from pipeline
- o_IRQ  out  1  request strobe to controller, one cycle high per grant
- o_ISR_addr  out  ADDR_W  vector of granted source, stable from o_IRQ until next grant
- o_active_id  out  ID_W  index of source in service
- o_busy  out  1  an ISR is in service

## Operation
- Edge detect: per source, prev register; event = src & ~prev. Event sets pending[i]. Pending is set for disabled sources too; only arbitration is masked.
- Arbitration: cand = pending & enable. Winner = lowest set index of cand, fixed priority, no rotation.
- Grant: latch o_ISR_addr = vec[winner] and o_active_id = winner, clear pending[winner], assert o_IRQ.
- If an edge on the winner arrives in the grant cycle, set wins and pending stays 1.
- FSM states:
  - IDLE: if cand != 0, grant and go to REQ.
  - REQ: o_IRQ = 1 for exactly this cycle; go to SERVICE.
  - SERVICE: o_busy = 1; wait for i_reti. On i_reti with cand != 0, grant and go to REQ (tail-chain). On i_reti with cand == 0, go to IDLE.
- i_reti in IDLE or REQ is ignored.
- No preemption: edges during SERVICE only accumulate in pending.
- Vector write to the entry of the active source does not alter the latched o_ISR_addr.
- Clearing an enable bit never clears pending; the source is granted once re-enabled.
- Simultaneous i_cfg_en_we and grant: arbitration uses the old mask in that cycle.
- Reset values:
  - o_IRQ 0, o_ISR_addr 0, o_active_id 0, o_busy 0
  - pending 0, enable 0, vector table 0, prev 0, FSM IDLE
- Reset mid-service drops the active ISR and all pending events without an o_IRQ.

## Timing
- Source edge sampled at cycle t (prev registered) → pending at t+1 → o_IRQ at t+2 when idle. That is 2 cycles without synchronizer.
- o_IRQ is high exactly one cycle and always low for at least one cycle between grants.
- o_busy rises in the cycle after o_IRQ, i.e. on entry to SERVICE.
- Tail-chain: i_reti at cycle t → o_IRQ at t+1 with the new o_ISR_addr. o_busy stays 1 throughout.
- Plain return: i_reti at t → o_busy 0 at t+1.
- Config writes take effect the cycle after the strobe.

## Configuration
- VIC_SYNC_EN defined: two-flop synchronizer on each i_irq_src bit ahead of edge detect. Source-to-o_IRQ latency becomes 4 cycles. Use for sources asynchronous to clk.
- VIC_SYNC_EN undefined: sources are used directly and must be synchronous to clk. Latency is 2 cycles.

## Test plan
- Reset, enable=0xFF, vec[3]=0x100, pulse src[3] → o_IRQ one cycle at t+2, o_ISR_addr=0x100, o_active_id=3, then o_busy=1.
- src[5] and src[2] rise in the same cycle → grant 2 first. i_reti → o_IRQ next cycle for 5 (tail-chain) with o_busy held 1.
- src[1] edge during service of 4 → no o_IRQ until i_reti. Then grant 1 at reti+1; a second i_reti → o_busy 0 next cycle.
- enable[6]=0, pulse src[6] → no o_IRQ. Set enable[6]=1 → o_IRQ 2 cycles after the enable write, id 6.
- While servicing 0, write vec[0]=0x200 → o_ISR_addr keeps its old value. Re-trigger src[0] and reti → new grant shows 0x200.
- Assert rst during SERVICE with pending bits set → all outputs 0 immediately. After release, no o_IRQ until a new edge.

Source files
------------

// File: rtl/vic_irq_arbiter_if.sv
// vic_irq_arbiter_if: source, configuration and request signals of the interrupt arbiter
interface vic_irq_arbiter_if #(
  parameter int N_SRC = 8,
  parameter int ADDR_W = 32
);
  localparam int ID_W = $clog2(N_SRC);
  logic [N_SRC-1:0] i_irq_src;
  logic i_cfg_vec_we;
  logic [ID_W-1:0] i_cfg_idx;
  logic [ADDR_W-1:0] i_cfg_vec;
  logic i_cfg_en_we;
  logic [N_SRC-1:0] i_cfg_en;
  logic i_reti;
  logic o_IRQ;
  logic [ADDR_W-1:0] o_ISR_addr;
  logic [ID_W-1:0] o_active_id;
  logic o_busy;
  modport master (
    output i_irq_src, i_cfg_vec_we, i_cfg_idx, i_cfg_vec, i_cfg_en_we, i_cfg_en, i_reti,
    input o_IRQ, o_ISR_addr, o_active_id, o_busy
  );
  modport slave (
    input i_irq_src, i_cfg_vec_we, i_cfg_idx, i_cfg_vec, i_cfg_en_we, i_cfg_en, i_reti,
    output o_IRQ, o_ISR_addr, o_active_id, o_busy
  );
endinterface

// File: rtl/vic_irq_arbiter.sv
// vic_irq_arbiter: edge-latched fixed-priority interrupt arbiter with vector table and tail-chaining (VIC_SYNC_EN adds a source synchronizer)
module vic_irq_arbiter #(
  parameter int N_SRC = 8,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  vic_irq_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_SRC);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state_q, state_d;
  logic [N_SRC-1:0] src, prev_q, pending_q, pending_d, enable_q, cand, evt, clr;
  logic [ADDR_W-1:0] vec_q [N_SRC];
  logic [ADDR_W-1:0] addr_q;
  logic [ID_W-1:0] id_q, winner;
  logic chain_q, grant;
`ifdef VIC_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;
  // two-flop synchronizer for sources asynchronous to clk
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.i_irq_src;
      sync2_q <= sync1_q;
    end
  assign src = sync2_q;
`else
  assign src = bus.i_irq_src;
`endif
  assign evt = src & ~prev_q;
  assign cand = pending_q & enable_q;
  // fixed priority: lowest candidate index wins
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (cand[i]) winner = ID_W'(i);
  end
  assign grant = (|cand) && (state_q == IDLE || (state_q == SERVICE && bus.i_reti));
  assign clr = grant ? (N_SRC'(1) << winner) : '0;
  assign pending_d = (pending_q & ~clr) | evt;
  // edge history, pending events (a new edge beats the grant clear) and enable mask
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prev_q <= '0;
      pending_q <= '0;
      enable_q <= '0;
    end else begin
      prev_q <= src;
      pending_q <= pending_d;
      if (bus.i_cfg_en_we) enable_q <= bus.i_cfg_en;
    end
  // ISR vector table
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < N_SRC; i++) vec_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) if (bus.i_cfg_vec_we && bus.i_cfg_idx == ID_W'(i)) vec_q[i] <= bus.i_cfg_vec;
    end
  // FSM state plus the vector/id captured at grant time
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      chain_q <= 1'b0;
      addr_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        chain_q <= state_q == SERVICE;
        addr_q <= vec_q[winner];
        id_q <= winner;
      end
    end
  // next state: grant always enters REQ; REQ lasts one cycle; plain return goes idle
  always_comb begin
    state_d = grant ? REQ : (state_q == REQ) ? SERVICE : (state_q == SERVICE && bus.i_reti) ? IDLE : state_q;
  end
  // outputs: busy also covers the strobe cycle of a tail-chained grant
  always_comb begin
    bus.o_IRQ = state_q == REQ;
    bus.o_busy = state_q == SERVICE || (state_q == REQ && chain_q);
    bus.o_ISR_addr = addr_q;
    bus.o_active_id = id_q;
  end
endmodule

// File: tb/tb_vic_irq_arbiter.sv
// tb_vic_irq_arbiter: directed and randomized checks of the interrupt arbiter against an output-level model
module tb_vic_irq_arbiter;
  localparam int N = 8;
  localparam int AW = 32;
  localparam int IW = $clog2(N);
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0, passed = 0, fails = 0;
  bit [N-1:0] m_pend, m_en, m_prev;
  logic [AW-1:0] m_vec [N];
  logic [AW-1:0] m_addr;
  int m_id;
  bit m_irq, m_busy;
  always #5 clk = ~clk;
  vic_irq_arbiter_if #(.N_SRC(N), .ADDR_W(AW)) bus ();
  vic_irq_arbiter #(.N_SRC(N), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(string tag, logic [AW-1:0] obs, logic [AW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_pend = '0;
    m_en = '0;
    m_prev = '0;
    m_addr = '0;
    m_id = 0;
    m_irq = 0;
    m_busy = 0;
    for (int i = 0; i < N; i++) m_vec[i] = '0;
  endtask
  task automatic tick();
    int w = -1;
    bit svc = m_busy && !m_irq;
    bit idle = !m_busy && !m_irq;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) w = i;
    if (w >= 0 && (idle || (svc && bus.i_reti))) begin
      m_busy = svc;
      m_irq = 1;
      m_addr = m_vec[w];
      m_id = w;
      m_pend[w] = 0;
    end else if (m_irq) begin
      m_irq = 0;
      m_busy = 1;
    end else if (svc && bus.i_reti) m_busy = 0;
    m_pend |= bus.i_irq_src & ~m_prev;
    m_prev = bus.i_irq_src;
    if (bus.i_cfg_en_we) m_en = bus.i_cfg_en;
    if (bus.i_cfg_vec_we) m_vec[bus.i_cfg_idx] = bus.i_cfg_vec;
    @(posedge clk);
    #1;
    check("m_irq", bus.o_IRQ, m_irq);
    check("m_busy", bus.o_busy, m_busy);
    check("m_addr", bus.o_ISR_addr, m_addr);
    check("m_id", bus.o_active_id, m_id);
  endtask
  task automatic pulse(bit [N-1:0] s);
    bus.i_irq_src = s;
    tick();
    bus.i_irq_src = '0;
    tick();
  endtask
  task automatic reti();
    bus.i_reti = 1'b1;
    tick();
    bus.i_reti = 1'b0;
  endtask
  task automatic wen(bit [N-1:0] m);
    bus.i_cfg_en_we = 1'b1;
    bus.i_cfg_en = m;
    tick();
    bus.i_cfg_en_we = 1'b0;
  endtask
  task automatic wvec(int idx, logic [AW-1:0] v);
    bus.i_cfg_vec_we = 1'b1;
    bus.i_cfg_idx = IW'(idx);
    bus.i_cfg_vec = v;
    tick();
    bus.i_cfg_vec_we = 1'b0;
  endtask
  task automatic check_zero(string tag);
    check({tag, "_irq"}, bus.o_IRQ, 0);
    check({tag, "_busy"}, bus.o_busy, 0);
    check({tag, "_addr"}, bus.o_ISR_addr, 0);
    check({tag, "_id"}, bus.o_active_id, 0);
  endtask
  initial begin
    bus.i_irq_src = '0;
    bus.i_cfg_vec_we = 1'b0;
    bus.i_cfg_idx = '0;
    bus.i_cfg_vec = '0;
    bus.i_cfg_en_we = 1'b0;
    bus.i_cfg_en = '0;
    bus.i_reti = 1'b0;
    m_reset();
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    wen(8'hFF);
    wvec(3, 'h100);
    wvec(2, 'h20);
    wvec(5, 'h50);
    wvec(4, 'h40);
    wvec(1, 'h10);
    wvec(6, 'h60);
    wvec(0, 'h0A);
    pulse(8'h08);
    check("first_irq", bus.o_IRQ, 1);
    check("first_addr", bus.o_ISR_addr, 'h100);
    check("first_id", bus.o_active_id, 3);
    check("first_busy_low", bus.o_busy, 0);
    tick();
    check("svc_busy", bus.o_busy, 1);
    check("svc_irq_low", bus.o_IRQ, 0);
    reti();
    check("ret_busy", bus.o_busy, 0);
    pulse(8'h24);
    check("prio_id", bus.o_active_id, 2);
    check("prio_addr", bus.o_ISR_addr, 'h20);
    tick();
    reti();
    check("chain_irq", bus.o_IRQ, 1);
    check("chain_id", bus.o_active_id, 5);
    check("chain_busy", bus.o_busy, 1);
    tick();
    reti();
    check("chain_ret_busy", bus.o_busy, 0);
    pulse(8'h10);
    check("svc4_id", bus.o_active_id, 4);
    tick();
    pulse(8'h02);
    check("nopreempt_irq", bus.o_IRQ, 0);
    check("nopreempt_id", bus.o_active_id, 4);
    tick();
    reti();
    check("late_irq", bus.o_IRQ, 1);
    check("late_id", bus.o_active_id, 1);
    tick();
    reti();
    check("late_ret_busy", bus.o_busy, 0);
    wen(8'hBF);
    pulse(8'h40);
    tick();
    check("masked_irq", bus.o_IRQ, 0);
    wen(8'hFF);
    tick();
    check("unmask_irq", bus.o_IRQ, 1);
    check("unmask_id", bus.o_active_id, 6);
    tick();
    reti();
    pulse(8'h01);
    check("src0_addr", bus.o_ISR_addr, 'h0A);
    tick();
    wvec(0, 'h200);
    check("vec_hold", bus.o_ISR_addr, 'h0A);
    pulse(8'h01);
    reti();
    check("vec_new_irq", bus.o_IRQ, 1);
    check("vec_new_addr", bus.o_ISR_addr, 'h200);
    tick();
    reti();
    pulse(8'h04);
    tick();
    bus.i_irq_src = 8'h22;
    tick();
    bus.i_irq_src = '0;
    tick();
    check("pre_rst_busy", bus.o_busy, 1);
    rst = 1'b0;
    #1;
    check_zero("midrst");
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    wen(8'hFF);
    tick();
    tick();
    check("post_rst_irq", bus.o_IRQ, 0);
    check("post_rst_busy", bus.o_busy, 0);
    for (int i = 0; i < N; i++) wvec(i, $urandom);
    for (int c = 0; c < 1500; c++) begin
      bus.i_irq_src = N'($urandom & $urandom);
      bus.i_reti = $urandom_range(3) == 0;
      bus.i_cfg_en_we = $urandom_range(19) == 0;
      bus.i_cfg_en = N'($urandom);
      bus.i_cfg_vec_we = $urandom_range(9) == 0;
      bus.i_cfg_idx = IW'($urandom_range(N - 1));
      bus.i_cfg_vec = $urandom;
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
